// File: rtl/sort_pkg.sv
// Shared types and helpers for the RAM bubble-sort controller: state encoding,
// word-count derivation and the ordering test.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    CMP,
    WR0,
    WR1,
    DONE
  } state_t;

  // Compare operands are zero-extended to this width, so DATA_WDTH must not exceed it.
  localparam int unsigned MAX_DATA_WDTH = 64;
  typedef logic [MAX_DATA_WDTH-1:0] word_max_t;

  function automatic int unsigned num_words(input int unsigned addr_wdth);
    return 32'd1 << addr_wdth;
  endfunction

  // True when the pair must be swapped; equal words never are.
  function automatic logic out_of_order(input word_max_t a, input word_max_t b,
                                        input logic descend);
    return descend ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/ram_sort_ctrl_if.sv
// Single-port RAM bus between the sort controller (master) and the external RAM (slave).
interface ram_sort_ctrl_if #(
    parameter int unsigned ADDR_WDTH = 4,
    parameter int unsigned DATA_WDTH = 32
);

    logic                 ram_wr_enable;
    logic                 ram_rd_enable;
    logic [ADDR_WDTH-1:0] ram_address;
    logic [DATA_WDTH-1:0] ram_wr_data;
    logic [DATA_WDTH-1:0] ram_rd_data;

    modport master (
        output ram_wr_enable,
        output ram_rd_enable,
        output ram_address,
        output ram_wr_data,
        input  ram_rd_data
    );

    modport slave (
        input  ram_wr_enable,
        input  ram_rd_enable,
        input  ram_address,
        input  ram_wr_data,
        output ram_rd_data
    );

endinterface

// File: rtl/ram_sort_ctrl.sv
// In-place bubble sort (with early exit) of an external registered-read RAM.
// RAM strobes, address and write data are decoded from state, i, a and b only.
module ram_sort_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned ADDR_WDTH = 4,
    parameter int unsigned DATA_WDTH = 32,
    parameter int unsigned DESCEND   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    ram_sort_ctrl_if.master   ram
);

    localparam int unsigned          N        = num_words(ADDR_WDTH);
    localparam logic [ADDR_WDTH-1:0] LAST_IDX = ADDR_WDTH'(N - 2);
    localparam logic [ADDR_WDTH-1:0] ONE      = ADDR_WDTH'(1);

    state_t               state, state_nxt;
    logic [ADDR_WDTH-1:0] i, i_nxt, p, p_nxt, last_i;
    logic [DATA_WDTH-1:0] a, a_nxt, b, b_nxt;
    logic                 flag, flag_nxt, advance;
    logic                 rd_en, wr_en;
    logic [ADDR_WDTH-1:0] addr;
    logic [DATA_WDTH-1:0] wdata;

    assign last_i = LAST_IDX - p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            p     <= '0;
            a     <= '0;
            b     <= '0;
            flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            p     <= p_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            flag  <= flag_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        p_nxt     = p;
        a_nxt     = a;
        b_nxt     = b;
        flag_nxt  = flag;
        advance   = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        addr      = '0;
        wdata     = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD0;
                    i_nxt     = '0;
                    p_nxt     = '0;
                    flag_nxt  = 1'b0;
                end
            end
            RD0: begin
                rd_en     = 1'b1;
                addr      = i;
                state_nxt = RD1;
            end
            RD1: begin
                rd_en     = 1'b1;
                addr      = i + ONE;
                a_nxt     = ram.ram_rd_data;
                state_nxt = CMP;
            end
            CMP: begin
                b_nxt = ram.ram_rd_data;
                if (out_of_order(word_max_t'(a), word_max_t'(ram.ram_rd_data), DESCEND != 0))
                    state_nxt = WR0;
                else
                    advance = 1'b1;
            end
            WR0: begin
                wr_en     = 1'b1;
                addr      = i;
                wdata     = b;
                state_nxt = WR1;
            end
            WR1: begin
                wr_en    = 1'b1;
                addr     = i + ONE;
                wdata    = a;
                flag_nxt = 1'b1;
                advance  = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // flag_nxt already includes a swap made in WR1, so only a clean pass exits early.
        if (advance) begin
            if (i < last_i) begin
                i_nxt     = i + ONE;
                state_nxt = RD0;
            end else if (!flag_nxt || p == LAST_IDX) begin
                state_nxt = DONE;
            end else begin
                p_nxt     = p + ONE;
                i_nxt     = '0;
                flag_nxt  = 1'b0;
                state_nxt = RD0;
            end
        end
    end

    assign busy              = (state != IDLE) && (state != DONE);
    assign done              = (state == DONE);
    assign ram.ram_rd_enable = rd_en;
    assign ram.ram_wr_enable = wr_en;
    assign ram.ram_address   = addr;
    assign ram.ram_wr_data   = wdata;

endmodule

// File: tb/tb_ram_sort_ctrl.sv
// Bench for ram_sort_ctrl: two controllers (ascending, descending) each beside a
// 4x8 registered-read RAM, driven from a vector table plus reset/restart sequences.
module tb_ram_sort_ctrl;

    typedef logic [3:0][7:0] ram4_t;

    typedef struct {
        logic  desc;
        ram4_t init;
        ram4_t exp;
        int    done_cycle;
        int    writes;
    } vec_t;

    logic  clk;
    logic  rst_n;
    logic  start0, start1;
    logic  busy0, busy1, done0, done1;
    logic  load0, load1;
    ram4_t init0, init1, mem0, mem1;
    int unsigned wr_cnt0 = 0, wr_cnt1 = 0, overlap0 = 0, overlap1 = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    ram_sort_ctrl_if #(.ADDR_WDTH(2), .DATA_WDTH(8)) bus0 ();
    ram_sort_ctrl_if #(.ADDR_WDTH(2), .DATA_WDTH(8)) bus1 ();

    ram_sort_ctrl #(.ADDR_WDTH(2), .DATA_WDTH(8), .DESCEND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .ram(bus0.master)
    );
    ram_sort_ctrl #(.ADDR_WDTH(2), .DATA_WDTH(8), .DESCEND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .ram(bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load0) mem0 <= init0;
        else if (bus0.ram_wr_enable) mem0[bus0.ram_address] <= bus0.ram_wr_data;
        if (bus0.ram_rd_enable) bus0.ram_rd_data <= mem0[bus0.ram_address];
        if (bus0.ram_wr_enable) wr_cnt0 <= wr_cnt0 + 1;
        if (bus0.ram_wr_enable && bus0.ram_rd_enable) overlap0 <= overlap0 + 1;
    end

    always @(posedge clk) begin
        if (load1) mem1 <= init1;
        else if (bus1.ram_wr_enable) mem1[bus1.ram_address] <= bus1.ram_wr_data;
        if (bus1.ram_rd_enable) bus1.ram_rd_data <= mem1[bus1.ram_address];
        if (bus1.ram_wr_enable) wr_cnt1 <= wr_cnt1 + 1;
        if (bus1.ram_wr_enable && bus1.ram_rd_enable) overlap1 <= overlap1 + 1;
    end

    function automatic ram4_t w4(input logic [7:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic get_done(input logic sel);
        return sel ? done1 : done0;
    endfunction

    function automatic logic get_busy(input logic sel);
        return sel ? busy1 : busy0;
    endfunction

    function automatic ram4_t get_mem(input logic sel);
        return sel ? mem1 : mem0;
    endfunction

    function automatic int unsigned get_wr(input logic sel);
        return sel ? wr_cnt1 : wr_cnt0;
    endfunction

    // {busy, done, rd, wr, address, wr_data} of the ascending controller
    function automatic logic [13:0] outs0();
        return {busy0, done0, bus0.ram_rd_enable, bus0.ram_wr_enable,
                bus0.ram_address, bus0.ram_wr_data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic load_ram(input logic sel, input ram4_t v);
        if (sel) begin init1 = v; load1 = 1'b1; end
        else     begin init0 = v; load0 = 1'b1; end
        @(posedge clk); #1;
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    task automatic set_start(input logic sel, input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int unsigned wr_before;
        int c;
        load_ram(v.desc, v.init);
        wr_before = get_wr(v.desc);
        @(posedge clk); #1;
        set_start(v.desc, 1'b1);
        @(posedge clk); #1;
        set_start(v.desc, 1'b0);
        c = 1;
        check({name, "_busy"}, 32'(get_busy(v.desc)), 32'd1);
        while (!get_done(v.desc) && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check({name, "_done_cycle"}, 32'(c), 32'(v.done_cycle));
        @(posedge clk); #1;
        check({name, "_idle_after"}, 32'({get_done(v.desc), get_busy(v.desc)}), 32'd0);
        check({name, "_ram"}, 32'(get_mem(v.desc)), 32'(v.exp));
        check({name, "_writes"}, get_wr(v.desc) - wr_before, 32'(v.writes));
    endtask

    initial begin
        vec_t vecs[7];
        int pulses, first_done, c;

        vecs[0] = '{1'b0, w4(0, 1, 2, 3),     w4(0, 1, 2, 3),     10, 0};
        vecs[1] = '{1'b0, w4(3, 2, 1, 0),     w4(0, 1, 2, 3),     31, 12};
        vecs[2] = '{1'b0, w4(2, 2, 1, 1),     w4(1, 1, 2, 2),     27, 8};
        vecs[3] = '{1'b1, w4(0, 1, 2, 3),     w4(3, 2, 1, 0),     31, 12};
        vecs[4] = '{1'b0, w4(1, 0, 3, 2),     w4(0, 1, 2, 3),     20, 4};
        vecs[5] = '{1'b1, w4(5, 5, 9, 1),     w4(9, 5, 5, 1),     23, 4};
        vecs[6] = '{1'b0, w4(255, 0, 128, 1), w4(0, 1, 128, 255), 27, 8};

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        load0  = 1'b0;
        load1  = 1'b0;
        init0  = '0;
        init1  = '0;
        #1;
        check("reset_outs0", 32'(outs0()), 32'd0);
        check("reset_outs1", 32'({busy1, done1, bus1.ram_rd_enable, bus1.ram_wr_enable,
                                  bus1.ram_address, bus1.ram_wr_data}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++)
            run_vec($sformatf("vec%0d", k), vecs[k]);

        // start held high for the whole sort: one done pulse, then a fresh sort
        load_ram(1'b0, w4(3, 1, 2, 0));
        @(posedge clk); #1;
        start0     = 1'b1;
        pulses     = 0;
        first_done = 0;
        for (int k = 1; k <= 29; k++) begin
            @(posedge clk); #1;
            if (done0) begin
                pulses++;
                if (first_done == 0) first_done = k;
            end
        end
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_done_cycle", 32'(first_done), 32'd29);
        @(posedge clk); #1;
        check("hold_idle", 32'({busy0, done0}), 32'd0);
        @(posedge clk); #1;
        check("hold_restart_busy", 32'(busy0), 32'd1);
        start0 = 1'b0;
        check("hold_ram", 32'(mem0), 32'(w4(0, 1, 2, 3)));
        c = 0;
        while (!done0 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check("hold_restart_done", 32'(done0), 32'd1);
        check("hold_restart_ram", 32'(mem0), 32'(w4(0, 1, 2, 3)));
        @(posedge clk); #1;

        // asynchronous reset landing in WR0 of the first swap
        load_ram(1'b0, w4(3, 1, 0, 2));
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wr0_reached", 32'({bus0.ram_wr_enable, bus0.ram_address}), 32'h4);
        rst_n = 1'b0;
        #1;
        check("rst_immediate", 32'(outs0()), 32'd0);
        @(posedge clk); #1;
        check("rst_next_cycle", 32'(outs0()), 32'd0);
        check("rst_ram_untouched", 32'(mem0), 32'(w4(3, 1, 0, 2)));
        rst_n = 1'b1;
        run_vec("after_rst", '{1'b0, w4(1, 3, 0, 2), w4(0, 1, 2, 3), 25, 6});

        check("no_rd_wr_overlap0", overlap0, 32'd0);
        check("no_rd_wr_overlap1", overlap1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
